// File: rtl/cpu_pkg.sv
// Shared definitions for the 6502 write-back slice.
// Contents:
//   reg_dest_t   - destination register selector carried with each EX result
//   wb_entry_t   - one buffered write-back entry (result byte, dest, new P, P write-enable)
//   P_*          - bit positions inside the processor status register
//   BUSY_*       - bit positions inside the busy vector reported to decode
//   fix_status   - applies the architectural fixed bits of P (U=1, B=0)
package cpu_pkg;

   typedef enum logic [2:0] {
      DEST_NONE = 3'd0,
      DEST_A    = 3'd1,
      DEST_X    = 3'd2,
      DEST_Y    = 3'd3,
      DEST_SP   = 3'd4
   } reg_dest_t;

   localparam int P_C = 0;
   localparam int P_Z = 1;
   localparam int P_I = 2;
   localparam int P_D = 3;
   localparam int P_B = 4;
   localparam int P_U = 5;
   localparam int P_V = 6;
   localparam int P_N = 7;

   localparam int BUSY_A  = 0;
   localparam int BUSY_X  = 1;
   localparam int BUSY_Y  = 2;
   localparam int BUSY_SP = 3;
   localparam int BUSY_P  = 4;

   typedef struct packed {
      logic [7:0] res;
      reg_dest_t  dest;
      logic [7:0] status;
      logic       status_we;
   } wb_entry_t;

   // The unused bit 5 always reads as 1 and the B flag never exists inside
   // the register itself (it only appears in pushed copies of P).
   function automatic logic [7:0] fix_status(input logic [7:0] s);
      logic [7:0] r;
      r      = s;
      r[P_U] = 1'b1;
      r[P_B] = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// Small FIFO of write-back entries sitting between EX and the register file.
// Ports:
//   clk, rst             - clock and asynchronous active-high reset
//   push, push_data      - enqueue one entry (caller guarantees not full)
//   pop                  - drop the head entry (caller guarantees not empty)
//   flush                - discard everything; wins over push and pop
//   head                 - oldest entry
//   count, full          - occupancy, registered
//   age_entry/age_valid  - all slots presented oldest-first with a valid flag,
//                          so the consumer can forward and compute busy bits
module wb_skid_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  wb_entry_t                  push_data,
   input  logic                       pop,
   input  logic                       flush,
   output wb_entry_t                  head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output wb_entry_t                  age_entry [DEPTH],
   output logic [DEPTH-1:0]           age_valid
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   wb_entry_t     mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
   // pointers simply roll over. A flush empties the buffer in one edge and
   // beats any push or pop issued in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage needs no reset: a slot is only ever looked at while the
   // occupancy count says it holds live data.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end

   assign head = mem[rd_ptr];
   assign full = (count == CW'(DEPTH));

   // Re-order the storage oldest-first so the youngest live entry is simply
   // the highest valid index.
   for (genvar i = 0; i < DEPTH; i++) begin : g_age
      assign age_entry[i] = mem[rd_ptr + PW'(i)];
      assign age_valid[i] = (CW'(i) < count);
   end

endmodule

// File: rtl/wb_regfile.sv
// Write-back end of the EX stage: buffers EX results in a skid FIFO and
// commits one per cycle into the 6502 architectural registers A, X, Y, SP, P.
// Ports:
//   clk_i, rst_i                  - clock, asynchronous active-high reset
//   ex_valid_i / ex_ready_o       - EX result handshake
//   alu_res_i, dest_i             - result (low byte used) and destination
//   status_reg_i, status_reg_we_i - new P and its write-enable
//   flush_i                       - discard all uncommitted entries
//   wb_stall_i                    - hold off commit this cycle
//   status_reg_o                  - P as the ALU must see it (forwarded)
//   a_o, x_o, y_o, sp_o           - architectural register values
//   busy_o                        - {P, SP, Y, X, A}: a pending entry writes it
module wb_regfile
   import cpu_pkg::*;
#(
   parameter int         DEPTH  = 2,
   parameter logic [7:0] SP_RST = 8'hFD,
   parameter logic [7:0] P_RST  = 8'h24
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ex_valid_i,
   output logic        ex_ready_o,
   input  logic [15:0] alu_res_i,
   input  reg_dest_t   dest_i,
   input  logic [7:0]  status_reg_i,
   input  logic        status_reg_we_i,
   input  logic        flush_i,
   input  logic        wb_stall_i,
   output logic [7:0]  status_reg_o,
   output logic [7:0]  a_o,
   output logic [7:0]  x_o,
   output logic [7:0]  y_o,
   output logic [7:0]  sp_o,
   output logic [4:0]  busy_o
);

   localparam int CW = $clog2(DEPTH+1);

   wb_entry_t        in_entry;
   wb_entry_t        head;
   wb_entry_t        age_entry [DEPTH];
   logic [DEPTH-1:0] age_valid;
   logic [CW-1:0]    count;
   logic             full;
   logic             push;
   logic             pop;
   logic [7:0]       p_q;
   logic [7:0]       fwd_status;
   logic             unused_res_hi;

   // Only the low byte of the ALU result reaches the 8-bit registers.
   assign unused_res_hi = ^alu_res_i[15:8];

   assign in_entry = '{res:       alu_res_i[7:0],
                       dest:      dest_i,
                       status:    status_reg_i,
                       status_we: status_reg_we_i};

   // Ready comes purely from the registered count, so a full buffer refuses
   // a new entry even in a cycle where it also commits, and stall has no
   // combinational route to ready.
   assign ex_ready_o = !full;
   assign push       = ex_valid_i && ex_ready_o && !flush_i;
   assign pop        = (count != '0) && !wb_stall_i && !flush_i;

   wb_skid_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .push      (push),
      .push_data (in_entry),
      .pop       (pop),
      .flush     (flush_i),
      .head      (head),
      .count     (count),
      .full      (full),
      .age_entry (age_entry),
      .age_valid (age_valid)
   );

   // Architectural registers. A commit applies the head entry's register
   // write and/or status write at this edge; a NONE entry without a status
   // write just disappears from the buffer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         a_o  <= '0;
         x_o  <= '0;
         y_o  <= '0;
         sp_o <= SP_RST;
         p_q  <= P_RST;
      end else if (pop) begin
         case (head.dest)
            DEST_A:  a_o  <= head.res;
            DEST_X:  x_o  <= head.res;
            DEST_Y:  y_o  <= head.res;
            DEST_SP: sp_o <= head.res;
            default: ;
         endcase
         if (head.status_we) begin
            p_q <= fix_status(head.status);
         end
      end
   end

   // Status forwarding: the youngest buffered status write wins, otherwise
   // the committed P. The live EX input is deliberately not forwarded since
   // it is itself computed from this output.
   always_comb begin
      fwd_status = p_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (age_valid[i] && age_entry[i].status_we) begin
            fwd_status = age_entry[i].status;
         end
      end
      status_reg_o = fix_status(fwd_status);
   end

   // Busy vector for decode: any live entry targeting a register marks it,
   // and any live status write marks P.
   always_comb begin
      busy_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (age_valid[i]) begin
            case (age_entry[i].dest)
               DEST_A:  busy_o[BUSY_A]  = 1'b1;
               DEST_X:  busy_o[BUSY_X]  = 1'b1;
               DEST_Y:  busy_o[BUSY_Y]  = 1'b1;
               DEST_SP: busy_o[BUSY_SP] = 1'b1;
               default: ;
            endcase
            if (age_entry[i].status_we) begin
               busy_o[BUSY_P] = 1'b1;
            end
         end
      end
   end

`ifndef SYNTHESIS
   // An unknown valid while we are able to accept would silently corrupt
   // the buffer, so flag it loudly in simulation.
   a_valid_known : assert property (@(posedge clk_i) disable iff (rst_i)
      ex_ready_o |-> !$isunknown(ex_valid_i));
`endif

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the EX stage interface of the NES 6502 core.
- Accepts the EX result: 16-bit ALU result, new status byte, status write-enable and destination select.
- Holds results in a 2-entry skid buffer and commits one per cycle into the architectural registers A, X, Y, SP and P.
- Returns the current P, with forwarding, as the status input of the ALU, and reports busy destinations so decode can stall.

Parameters:
- DEPTH, 2, skid buffer entries (power of two, at least 2).
- SP_RST, 8'hFD, stack pointer reset value.
- P_RST, 8'h24, status register reset value (I=1, bit5=1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- ex_valid_i  in  1  EX result valid.
- ex_ready_o  out  1  buffer can accept.
- alu_res_i  in  16  ALU result; only bits [7:0] are written to 8-bit registers.
- dest_i  in  3  reg_dest_t: NONE, A, X, Y, SP.
- status_reg_i  in  8  new P produced by the ALU.
- status_reg_we_i  in  1  write P with status_reg_i.
- flush_i  in  1  synchronous discard of all uncommitted entries.
- wb_stall_i  in  1  inhibit commit this cycle.
- status_reg_o  out  8  forwarded P, fed to the ALU status input.
- a_o, x_o, y_o, sp_o  out  8 each  architectural register values.
- busy_o  out  5  one-hot per dest (A, X, Y, SP, P): a pending entry writes it.

Behaviour:
- Reset values: A=X=Y=0, SP=SP_RST, P=P_RST, buffer empty, ex_ready_o=1, busy_o=0, status_reg_o=P_RST. Reset asserted mid-operation discards all pending entries; architectural registers return to reset values.
- Enqueue: an entry {res[7:0], dest, status, status_we} is enqueued when ex_valid_i && ex_ready_o && !flush_i.
- Ready: ex_ready_o = (count != DEPTH), decoded from registered count only.
  - A full buffer that commits in the same cycle still refuses the new entry.
  - No combinational path from wb_stall_i to ex_ready_o.
- Commit: when count>0 && !wb_stall_i && !flush_i, the head entry is popped and its writes apply at that clock edge.
  - dest!=NONE: the register gets res[7:0].
  - status_we=1: P gets status, with bit5 forced to 1 and bit4 (B) forced to 0.
  - dest NONE with status_we=0 is legal: pop only.
- Commit latency: 1 cycle from enqueue with an empty buffer and no stall. Throughput: 1 entry per cycle sustained (simultaneous enqueue and commit, count unchanged).
- Count: enqueue only: +1. Commit only: -1. Both: unchanged. Read/write pointers wrap modulo DEPTH.
- Flush: count=0 and pointers reset on the next edge. Takes priority over both enqueue and commit in the same cycle. Architectural registers are untouched.
- status_reg_o (combinational):
  - equals the status field of the youngest buffered entry with status_we=1;
  - else architectural P;
  - bit5=1 and bit4=0 in all cases.
  - Does not forward the incoming ex input in the same cycle (no comb loop through the ALU).
- busy_o[d]: OR over valid entries whose dest==d; the P bit is set if any valid entry has status_we=1. Registered inputs only.
- a_o, x_o, y_o, sp_o: architectural values only, no forwarding. SP wraps naturally at 8 bits; no overflow detection here.
- An X or Z on ex_valid_i while ready is a simulation assertion error.

Decomposition:
- Package cpu_pkg: reg_dest_t enum (NONE=0, A, X, Y, SP), wb_entry_t struct, and the P bit-index constants C=0, Z=1, I=2, D=3, B=4, U=5, V=6, N=7.
- One sub-module, wb_skid_fifo: generic DEPTH FIFO of wb_entry_t with count, flush and per-entry valid vector exposed for forwarding and busy.
- wb_regfile holds the architectural registers, forwarding mux and busy logic.

Test Plan:
- Reset then idle: a_o=0, x_o=0, y_o=0, sp_o=FD, status_reg_o=24, ex_ready_o=1, busy_o=0; assert rst_i async between edges, outputs return immediately.
- Single commit: enqueue res=16'h12AB, dest=A, status=8'h80, we=1 -> next cycle a_o=AB, status_reg_o=A0 (bit5 forced), busy_o=0.
- Stall fill: hold wb_stall_i=1 and enqueue X=01 (P=25), then Y=02 (no P) -> ex_ready_o=0, busy_o X|Y|P set, status_reg_o=25 before any commit. Release stall -> x_o=01, y_o=02 on consecutive cycles.
- Full plus commit same cycle: with buffer full and stall dropped, third valid held -> not accepted until ex_ready_o=1, then accepted; no entry lost or duplicated (scoreboard order A, X, Y).
- Flush: two pending entries to SP, flush_i=1 with ex_valid_i=1 -> buffer empty, sp_o still FD, new entry dropped, busy_o=0.
- B-bit masking: status=8'hFF, we=1 -> P=EF; dest NONE and we=0 entry -> pops, no register change.
